// File: rtl/si5338_pkg.sv
// SI5338 bring-up constants: page-0 register addresses, status masks,
// basic_iic start codes, error codes and the shared FSM / ROM entry types.
package si5338_pkg;

  localparam logic [7:0] REG_FCAL_OVRD0   = 8'd45;
  localparam logic [7:0] REG_FCAL_OVRD1   = 8'd46;
  localparam logic [7:0] REG_FCAL_OVRD2   = 8'd47;
  localparam logic [7:0] REG_FCAL_OVRD_EN = 8'd49;
  localparam logic [7:0] REG_STATUS       = 8'd218;
  localparam logic [7:0] REG_OEB_ALL      = 8'd230;
  localparam logic [7:0] REG_FCAL0        = 8'd235;
  localparam logic [7:0] REG_FCAL1        = 8'd236;
  localparam logic [7:0] REG_FCAL2        = 8'd237;
  localparam logic [7:0] REG_LOL_CTRL     = 8'd241;
  localparam logic [7:0] REG_SOFT_RST     = 8'd246;

  localparam logic [7:0] LOS_MASK  = 8'h04;
  localparam logic [7:0] LOCK_MASK = 8'h15;

  localparam logic [1:0] IIC_IDLE = 2'b00;
  localparam logic [1:0] IIC_WR   = 2'b01;
  localparam logic [1:0] IIC_RD   = 2'b10;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_LOS  = 3'd1;
  localparam logic [2:0] ERR_LOCK = 3'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_OEB, S_PLOL, S_MAP, S_LOS, S_FCALC, S_SRST, S_WAIT,
    S_RLOL, S_LOCK, S_CPY, S_FCALS, S_OEN, S_DONE, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    U_IDLE, U_RD, U_WAIT_RD, U_WR, U_WAIT_WR, U_GAP
  } uop_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] mask;
  } rom_entry_t;

  function automatic logic [7:0] rmw_merge(input logic [7:0] cur, input logic [7:0] data,
                                           input logic [7:0] mask);
    return (cur & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/si5338_reg_rom.sv
// SI5338 register map ROM, one {addr,data,mask} entry per index, registered output
// (one cycle read latency). Contents come from the map generator as a packed parameter.
module si5338_reg_rom
  import si5338_pkg::*;
#(
  parameter int                   N_REGS = 349,
  parameter int                   AW     = 9,
  parameter logic [N_REGS*24-1:0] INIT   = '0
) (
  input  logic          CLK,
  input  logic [AW-1:0] i_idx,
  output rom_entry_t    o_q
);

  logic [23:0] w_rom [N_REGS];
  rom_entry_t  r_q;

  for (genvar g = 0; g < N_REGS; g++) begin : g_rom
    assign w_rom[g] = INIT[g*24 +: 24];
  end

  always_ff @(posedge CLK) begin
    r_q <= rom_entry_t'(w_rom[i_idx]);
  end

  assign o_q = r_q;

endmodule

// File: rtl/arria_v_si5338_cfg_seq.sv
// SI5338 bring-up sequencer: OEB, LOL pause, masked map load, LOS/lock polling, FCAL copy, output enable.
// One basic_iic transfer at a time; each transfer is held until iic_done, then at least one idle cycle.
module arria_v_si5338_cfg_seq
  import si5338_pkg::*;
#(
  parameter int                   N_REGS     = 349,
  parameter int                   CLK_HZ     = 50_000_000,
  parameter int                   POLL_LIMIT = 1000,
  parameter logic [N_REGS*24-1:0] ROM_INIT   = '0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  output logic [1:0] iic_start,
  output logic [7:0] iic_addr,
  output logic [7:0] iic_wr_data,
  input  logic [7:0] iic_rd_data,
  input  logic       iic_done,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_err,
  output logic [2:0] err_code
);

  localparam int IDXW     = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int POLLW    = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
  localparam int WAIT_CYC = (CLK_HZ / 40 > 0) ? CLK_HZ / 40 : 1;
  localparam int WAITW    = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  state_t           r_state;
  uop_t             r_uop;
  logic [IDXW-1:0]  r_idx;
  logic             r_rom_rdy;
  logic [POLLW-1:0] r_poll;
  logic [WAITW-1:0] r_wait;
  logic [2:0]       r_step;
  logic [7:0]       r_addr, r_data, r_mask, r_rd, r_f0, r_f1, r_f2;
  logic             r_rdonly;
  logic [1:0]       r_iic_start;
  logic [7:0]       r_iic_addr, r_iic_wr_data;
  logic             r_busy, r_cfg_done, r_cfg_err;
  logic [2:0]       r_err_code;

  rom_entry_t       w_rom_q;
  logic [7:0]       w_addr, w_data, w_mask;
  logic             w_rdonly, w_poll_ok;

  si5338_reg_rom #(.N_REGS(N_REGS), .AW(IDXW), .INIT(ROM_INIT)) u_rom (
    .CLK   (CLK),
    .i_idx (r_idx),
    .o_q   (w_rom_q)
  );

  // Transfer descriptor for the current step; mask FF = plain write, 00 = skip.
  always_comb begin
    w_addr   = 8'h00;
    w_data   = 8'h00;
    w_mask   = 8'hFF;
    w_rdonly = 1'b0;
    case (r_state)
      S_OEB:   begin w_addr = REG_OEB_ALL;  w_data = 8'h10; end
      S_PLOL:  begin w_addr = REG_LOL_CTRL; w_data = 8'hE5; end
      S_MAP:   begin w_addr = w_rom_q.addr; w_data = w_rom_q.data; w_mask = w_rom_q.mask; end
      S_LOS,
      S_LOCK:  begin w_addr = REG_STATUS; w_rdonly = 1'b1; end
      S_FCALC: begin w_addr = REG_FCAL_OVRD_EN; w_data = 8'h00; w_mask = 8'h80; end
      S_SRST:  begin w_addr = REG_SOFT_RST; w_data = 8'h02; end
      S_RLOL:  begin w_addr = REG_LOL_CTRL; w_data = 8'h65; end
      S_CPY: begin
        case (r_step)
          3'd0:    begin w_addr = REG_FCAL2; w_rdonly = 1'b1; end
          3'd1:    begin w_addr = REG_FCAL1; w_rdonly = 1'b1; end
          3'd2:    begin w_addr = REG_FCAL0; w_rdonly = 1'b1; end
          3'd3:    begin w_addr = REG_FCAL_OVRD0; w_data = r_f0; end
          3'd4:    begin w_addr = REG_FCAL_OVRD1; w_data = r_f1; end
          3'd5:    begin w_addr = REG_FCAL_OVRD2; w_data = r_f2; w_mask = 8'h03; end
          default: begin w_addr = REG_FCAL_OVRD2; w_data = 8'h14; w_mask = 8'hFC; end
        endcase
      end
      S_FCALS: begin w_addr = REG_FCAL_OVRD_EN; w_data = 8'h80; w_mask = 8'h80; end
      S_OEN:   begin w_addr = REG_OEB_ALL; w_data = 8'h00; end
      default: ;
    endcase
  end

  assign w_poll_ok = (r_rd & ((r_state == S_LOCK) ? LOCK_MASK : LOS_MASK)) == 8'h00;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= S_IDLE;
      r_uop         <= U_IDLE;
      r_idx         <= '0;
      r_rom_rdy     <= 1'b0;
      r_poll        <= '0;
      r_wait        <= '0;
      r_step        <= '0;
      r_addr        <= 8'h00;
      r_data        <= 8'h00;
      r_mask        <= 8'h00;
      r_rd          <= 8'h00;
      r_f0          <= 8'h00;
      r_f1          <= 8'h00;
      r_f2          <= 8'h00;
      r_rdonly      <= 1'b0;
      r_iic_start   <= IIC_IDLE;
      r_iic_addr    <= 8'h00;
      r_iic_wr_data <= 8'h00;
      r_busy        <= 1'b0;
      r_cfg_done    <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_err_code    <= ERR_NONE;
    end else begin
      case (r_uop)
        U_IDLE: begin
          if (r_state == S_IDLE) begin
            if (start) begin
              r_state <= S_OEB;
              r_busy  <= 1'b1;
            end
          end else if (r_state == S_WAIT) begin
            if (r_wait == WAITW'(WAIT_CYC - 1)) r_state <= S_RLOL;
            else r_wait <= r_wait + WAITW'(1);
          end else if (r_state == S_MAP && !r_rom_rdy) begin
            r_rom_rdy <= 1'b1;  // ROM output for the new index lands next cycle
          end else if (r_state != S_DONE && r_state != S_ERR) begin
            r_rom_rdy <= 1'b0;
            r_addr    <= w_addr;
            r_data    <= w_data;
            r_mask    <= w_mask;
            r_rdonly  <= w_rdonly;
            if (w_rdonly)              r_uop <= U_RD;
            else if (w_mask == 8'h00)  r_uop <= U_GAP;
            else if (w_mask == 8'hFF)  r_uop <= U_WR;
            else                       r_uop <= U_RD;
          end
        end
        U_RD: begin
          r_iic_start <= IIC_RD;
          r_iic_addr  <= r_addr;
          r_uop       <= U_WAIT_RD;
        end
        U_WAIT_RD: if (iic_done) begin
          r_iic_start <= IIC_IDLE;
          r_rd        <= iic_rd_data;
          r_data      <= rmw_merge(iic_rd_data, r_data, r_mask);
          r_uop       <= r_rdonly ? U_GAP : U_WR;
        end
        U_WR: begin
          r_iic_start   <= IIC_WR;
          r_iic_addr    <= r_addr;
          r_iic_wr_data <= r_data;
          r_uop         <= U_WAIT_WR;
        end
        U_WAIT_WR: if (iic_done) begin
          r_iic_start <= IIC_IDLE;
          r_uop       <= U_GAP;
        end
        U_GAP: begin
          r_uop <= U_IDLE;
          case (r_state)
            S_OEB:   r_state <= S_PLOL;
            S_PLOL:  begin r_state <= S_MAP; r_idx <= '0; end
            S_MAP: begin
              if (r_idx == IDXW'(N_REGS - 1)) begin
                r_state <= S_LOS;
                r_poll  <= '0;
              end else begin
                r_idx <= r_idx + IDXW'(1);
              end
            end
            S_LOS, S_LOCK: begin
              if (w_poll_ok) begin
                r_state <= (r_state == S_LOS) ? S_FCALC : S_CPY;
                r_step  <= '0;
              end else if (r_poll == POLLW'(POLL_LIMIT - 1)) begin
                r_state    <= S_ERR;
                r_busy     <= 1'b0;
                r_cfg_err  <= 1'b1;
                r_err_code <= (r_state == S_LOS) ? ERR_LOS : ERR_LOCK;
              end else begin
                r_poll <= r_poll + POLLW'(1);
              end
            end
            S_FCALC: r_state <= S_SRST;
            S_SRST:  begin r_state <= S_WAIT; r_wait <= '0; end
            S_RLOL:  begin r_state <= S_LOCK; r_poll <= '0; end
            S_CPY: begin
              if (r_step == 3'd0) r_f2 <= r_rd;
              if (r_step == 3'd1) r_f1 <= r_rd;
              if (r_step == 3'd2) r_f0 <= r_rd;
              if (r_step == 3'd6) r_state <= S_FCALS;
              else r_step <= r_step + 3'd1;
            end
            S_FCALS: r_state <= S_OEN;
            S_OEN: begin
              r_state    <= S_DONE;
              r_busy     <= 1'b0;
              r_cfg_done <= 1'b1;
            end
            default: ;
          endcase
        end
        default: r_uop <= U_IDLE;
      endcase
    end
  end

  assign iic_start   = r_iic_start;
  assign iic_addr    = r_iic_addr;
  assign iic_wr_data = r_iic_wr_data;
  assign busy        = r_busy;
  assign cfg_done    = r_cfg_done;
  assign cfg_err     = r_cfg_err;
  assign err_code    = r_err_code;

endmodule
